// File: rtl/mm2s_rd_sched.sv
// Round-robin arbiter that shares one AXI read-address channel among NREQ requesters,
// applying the cache/prot/user policy latched at grant and capping outstanding bursts.
module mm2s_rd_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned MAX_OUT = 8,
  parameter int unsigned IDW     = 3
) (
  input  logic              clk_100_clk,
  input  logic              reset_reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_len,
  input  logic [NREQ*4-1:0] req_cache,
  input  logic [NREQ*3-1:0] req_prot,
  input  logic [NREQ*5-1:0] req_user,
  input  logic [1:0]        cfg_mode,
  output logic [AW-1:0]     m_araddr,
  output logic [7:0]        m_arlen,
  output logic [IDW-1:0]    m_arid,
  output logic [3:0]        m_arcache,
  output logic [2:0]        m_arprot,
  output logic [4:0]        m_aruser,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic              m_rready,
  input  logic              m_rlast,
  output logic [7:0]        outstanding,
  output logic              busy,
  output logic              err_underflow
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int N = int'(NREQ);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]      out_q, out_d;
  logic            err_q, err_d;
  logic [AW-1:0]   addr_q;
  logic [7:0]      len_q;
  logic [IDW-1:0]  id_q;
  logic [3:0]      cache_q;
  logic [2:0]      prot_q;
  logic [4:0]      user_q;

  logic            any_valid;
  logic [PW-1:0]   winner;
  logic            grant;
  logic            ar_hs;
  logic            r_done;
  logic [AW-1:0]   sel_addr;
  logic [7:0]      sel_len;
  logic [3:0]      sel_cache;
  logic [2:0]      sel_prot;
  logic [4:0]      sel_user;

  // Scan downward so the lowest offset from the pointer wins.
  always_comb begin
    int idx;
    any_valid = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % N;
      if (req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = PW'(idx);
      end
    end
  end

  assign grant = (state_q == StIdle) && any_valid && (cfg_mode != 2'b11) &&
                 (32'(out_q) < MAX_OUT);

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  // Attribute policy is resolved here so the held AR is immune to later mode changes.
  always_comb begin
    int wi;
    wi        = int'(winner);
    sel_addr  = req_addr[wi*int'(AW) +: AW];
    sel_len   = req_len[wi*8 +: 8];
    sel_prot  = req_prot[wi*3 +: 3];
    sel_cache = req_cache[wi*4 +: 4];
    sel_user  = req_user[wi*5 +: 5];
    case (cfg_mode)
      2'b01: begin
        sel_cache = 4'hF;
        sel_user  = 5'h01;
      end
      2'b10: begin
        sel_cache = 4'h3;
        sel_user  = 5'h00;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (grant) begin
          state_d  = StIssue;
          rr_ptr_d = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
        end
      end
      StIssue: begin
        if (m_arready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ar_hs  = (state_q == StIssue) && m_arready;
  assign r_done = m_rvalid && m_rready && m_rlast;

  always_comb begin
    out_d = out_q;
    err_d = err_q;
    if (ar_hs && !r_done) begin
      out_d = out_q + 8'd1;
    end else if (!ar_hs && r_done) begin
      if (out_q == 8'd0) err_d = 1'b1;
      else               out_d = out_q - 8'd1;
    end
  end

  always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      id_q     <= '0;
      cache_q  <= '0;
      prot_q   <= '0;
      user_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      out_q    <= out_d;
      err_q    <= err_d;
      if (grant) begin
        addr_q  <= sel_addr;
        len_q   <= sel_len;
        id_q    <= IDW'(winner);
        cache_q <= sel_cache;
        prot_q  <= sel_prot;
        user_q  <= sel_user;
      end
    end
  end

  assign m_arvalid     = (state_q == StIssue);
  assign m_araddr      = addr_q;
  assign m_arlen       = len_q;
  assign m_arid        = id_q;
  assign m_arcache     = cache_q;
  assign m_arprot      = prot_q;
  assign m_aruser      = user_q;
  assign outstanding   = out_q;
  assign busy          = (out_q != 8'd0) || m_arvalid;
  assign err_underflow = err_q;

endmodule
